// File: rtl/ex_mem.sv
// EX/MEM pipeline register with flush/stall handling and multi-cycle MAC feedback.
// Optional perf counters enabled by defining EX_MEM_PERF_CNT_EN.
module ex_mem #(
  parameter int unsigned STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [4:0]         ex_wd,
  input  logic               ex_wreg,
  input  logic [31:0]        ex_wdata,
  input  logic               ex_whilo,
  input  logic [31:0]        ex_hi,
  input  logic [31:0]        ex_lo,
  input  logic [63:0]        hilo_temp_i,
  input  logic [1:0]         cnt_i,
  output logic [4:0]         mem_wd,
  output logic               mem_wreg,
  output logic [31:0]        mem_wdata,
  output logic               mem_whilo,
  output logic [31:0]        mem_hi,
  output logic [31:0]        mem_lo,
  output logic [63:0]        hilo_temp_o,
  output logic [1:0]         cnt_o
`ifdef EX_MEM_PERF_CNT_EN
  ,
  output logic [31:0]        perf_inst_cnt,
  output logic [31:0]        perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {UpdFlush, UpdBubble, UpdAdvance, UpdHold} upd_e;

  upd_e upd;

  // stall[3]=0 with stall[4]=1 is illegal and falls through to Advance.
  always_comb begin
    upd = UpdHold;
    if (flush) begin
      upd = UpdFlush;
    end else if (stall[3] && !stall[4]) begin
      upd = UpdBubble;
    end else if (!stall[3]) begin
      upd = UpdAdvance;
    end else begin
      upd = UpdHold;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wd      <= '0;
      mem_wreg    <= 1'b0;
      mem_wdata   <= '0;
      mem_whilo   <= 1'b0;
      mem_hi      <= '0;
      mem_lo      <= '0;
      hilo_temp_o <= '0;
      cnt_o       <= '0;
    end else begin
      unique case (upd)
        UpdFlush: begin
          mem_wd      <= '0;
          mem_wreg    <= 1'b0;
          mem_wdata   <= '0;
          mem_whilo   <= 1'b0;
          mem_hi      <= '0;
          mem_lo      <= '0;
          hilo_temp_o <= '0;
          cnt_o       <= '0;
        end
        UpdBubble: begin
          mem_wd      <= '0;
          mem_wreg    <= 1'b0;
          mem_wdata   <= '0;
          mem_whilo   <= 1'b0;
          mem_hi      <= '0;
          mem_lo      <= '0;
          // Keep partial MAC state alive while execute is stalled.
          hilo_temp_o <= hilo_temp_i;
          cnt_o       <= cnt_i;
        end
        UpdAdvance: begin
          mem_wd      <= ex_wd;
          mem_wreg    <= ex_wreg;
          mem_wdata   <= ex_wdata;
          mem_whilo   <= ex_whilo;
          mem_hi      <= ex_hi;
          mem_lo      <= ex_lo;
          hilo_temp_o <= '0;
          cnt_o       <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef EX_MEM_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_inst_cnt   <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (upd == UpdAdvance && (ex_wreg || ex_whilo)) begin
        perf_inst_cnt <= perf_inst_cnt + 32'd1;
      end
      if (upd == UpdBubble) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
    end
  end
`endif

  a_no_mem_stall_without_ex : assert property (
    @(posedge clk) disable iff (rst) !(!stall[3] && stall[4])
  );

endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS core.
- Latches the execute results (destination register, write enable, write data, HI/LO write) on each clock and presents them to the memory stage.
- Honours the central stall vector and the flush signal from the control unit.
- Holds the intermediate 64-bit product and cycle counter for two-cycle multiply-accumulate instructions, and feeds them back to the execute stage.

Parameters:
- STALL_W, 6, width of the stall vector; bit 3 = execute stage, bit 4 = memory stage.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high (1 = RstEnable)
- stall  in  6  per-stage stall request from the control unit
- flush  in  1  pipeline flush (exception/eret)
- ex_wd  in  5  destination register address from execute
- ex_wreg  in  1  GPR write enable from execute
- ex_wdata  in  32  GPR write data from execute
- ex_whilo  in  1  HI/LO write enable from execute
- ex_hi  in  32  HI write value
- ex_lo  in  32  LO write value
- hilo_temp_i  in  64  partial product produced by execute in cycle 1 of a multi-cycle op
- cnt_i  in  2  multi-cycle step counter produced by execute
- mem_wd  out  5  registered destination address
- mem_wreg  out  1  registered GPR write enable
- mem_wdata  out  32  registered GPR write data
- mem_whilo  out  1  registered HI/LO write enable
- mem_hi  out  32  registered HI value
- mem_lo  out  32  registered LO value
- hilo_temp_o  out  64  partial product returned to execute
- cnt_o  out  2  step counter returned to execute

Behaviour:
- Reset (rst=1, asynchronous): all outputs 0 immediately, independent of clk.
- Update priority on each rising edge with rst=0: flush, then bubble, then advance, then hold.
- Flush (flush=1), regardless of stall:
  - All mem_* outputs cleared to 0.
  - hilo_temp_o=0, cnt_o=0.
- Bubble (stall[3]=1 and stall[4]=0), execute stalled while memory proceeds:
  - All mem_* outputs cleared to 0 (NOP: mem_wreg=0, mem_whilo=0).
  - hilo_temp_o<=hilo_temp_i, cnt_o<=cnt_i, so a multi-cycle op keeps its partial state across the stall.
- Advance (stall[3]=0):
  - Each mem_* output takes its ex_* input.
  - hilo_temp_o<=0, cnt_o<=0: the multi-cycle op completed or none was in flight.
- Hold (stall[3]=1 and stall[4]=1): every output keeps its value.
- Latency: exactly one cycle from ex_* to mem_*, with no combinational path from inputs to outputs.
- Stall bits other than 3 and 4 are ignored.
- The combination stall[3]=0 with stall[4]=1 is illegal from the control unit. If it occurs, treat it as Advance; an assertion flags it in simulation.
- Reset asserted mid multi-cycle op: cnt_o/hilo_temp_o return to 0, and execute restarts the op from step 0.

Optional Feature:
- Macro: EX_MEM_PERF_CNT_EN.
- With the macro defined, two extra output ports are present:
  - perf_inst_cnt (32): increments on each Advance edge where ex_wreg|ex_whilo=1.
  - perf_bubble_cnt (32): increments on each Bubble edge.
- Counter rules:
  - Both counters wrap modulo 2^32.
  - Both hold during Hold and Flush.
  - Both reset to 0 asynchronously.
- Without the macro: the ports and counters are absent, and functional behaviour is otherwise identical.

Test Plan:
- Async reset: drive all inputs nonzero, pulse rst high between clock edges → all outputs 0 at once; after release plus one edge with stall=0, mem_wdata=ex_wdata (e.g. 0x0000_1234).
- Advance: ex_wd=5'd3, ex_wreg=1, ex_wdata=0xFFFF_0F0F, stall=0 → the next edge gives mem_wd=3, mem_wreg=1, mem_wdata=0xFFFF_0F0F, cnt_o=0.
- Bubble with multi-cycle state: stall=6'b001000, hilo_temp_i=0x0000_0001_0000_0002, cnt_i=2'b01, ex_wreg=1 → mem_wreg=0, mem_wdata=0, hilo_temp_o=0x0000_0001_0000_0002, cnt_o=1.
- Hold: load mem_wdata=0xA5A5_A5A5, then stall=6'b011000 for 3 cycles with changing inputs → mem_wdata stays 0xA5A5_A5A5 throughout.
- Flush beats stall: stall=6'b001000, flush=1, cnt_i=1 → all outputs 0, including cnt_o.
- Perf counters (EX_MEM_PERF_CNT_EN): 4 Advance cycles with ex_wreg=1, then 2 Bubble cycles → perf_inst_cnt=4, perf_bubble_cnt=2; preload perf_inst_cnt=0xFFFF_FFFF, then one Advance → wraps to 0.
